// File: rtl/snake_engine.sv
`default_nettype none
// ============================================================================
// snake_engine: snake game core with head move, growth, and segment scan-out.
// Optional macro SNAKE_WRAP_EN selects wrap-around walls instead of fatal walls.
// Revision: 1.0
// ============================================================================
module snake_engine #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 14,
  parameter int MAX_LEN   = 64,
  parameter int GROW_STEP = 1,
  parameter int START_X   = 8,
  parameter int START_Y   = 7,
  localparam int XW = $clog2(GRID_W + 2),
  localparam int YW = $clog2(GRID_H + 2),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic [1:0]    i_dir,
  input  logic          i_eat,
  output logic          o_tick_done,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  output logic [1:0]    o_head_dir,
  output logic [XW-1:0] o_pos_x,
  output logic [YW-1:0] o_pos_y,
  output logic [1:0]    o_pos_dir,
  output logic          o_pos_first,
  output logic          o_pos_last,
  output logic          o_pos_valid,
  output logic [LW-1:0] o_length,
  output logic          o_failure,
  output logic          o_success
);

  localparam int HN = 1 << LW;
  localparam int PW = LW + 5;

  typedef enum logic [1:0] {WAIT = 2'd0, MOVE = 2'd1, SCAN = 2'd2} state_t;

  state_t        state;
  logic [1:0]    hist [HN];
  logic [LW-1:0] pending;
  logic [LW-1:0] idx;

  // back=1 steps against the direction, used when walking from head to tail
  function automatic logic [XW-1:0] mv_x(input logic [XW-1:0] x, input logic [1:0] d,
                                         input logic back);
    logic          inc;
    logic [XW-1:0] r;
    inc = d[0] ^ back;
    r   = x;
    if (d[1]) begin
`ifdef SNAKE_WRAP_EN
      if (inc) r = (x == XW'(GRID_W)) ? XW'(1) : x + XW'(1);
      else     r = (x == XW'(1)) ? XW'(GRID_W) : x - XW'(1);
`else
      r = inc ? x + XW'(1) : x - XW'(1);
`endif
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] mv_y(input logic [YW-1:0] y, input logic [1:0] d,
                                         input logic back);
    logic          inc;
    logic [YW-1:0] r;
    inc = d[0] ^ back;
    r   = y;
    if (!d[1]) begin
`ifdef SNAKE_WRAP_EN
      if (inc) r = (y == YW'(GRID_H)) ? YW'(1) : y + YW'(1);
      else     r = (y == YW'(1)) ? YW'(GRID_H) : y - YW'(1);
`else
      r = inc ? y + YW'(1) : y - YW'(1);
`endif
    end
    return r;
  endfunction

  logic [1:0]    eff_dir;
  logic [XW-1:0] nx, sx;
  logic [YW-1:0] ny, sy;
  logic          grow;
  logic [LW-1:0] new_len, nidx;
  logic [PW-1:0] psum;
  logic          wall_hit;

  always_comb begin
    eff_dir  = ((i_dir ^ o_head_dir) == 2'b01) ? o_head_dir : i_dir;
    nx       = mv_x(o_head_x, eff_dir, 1'b0);
    ny       = mv_y(o_head_y, eff_dir, 1'b0);
    sx       = mv_x(o_pos_x, o_pos_dir, 1'b1);
    sy       = mv_y(o_pos_y, o_pos_dir, 1'b1);
    grow     = (state == MOVE) && (pending != '0) && (o_length < LW'(MAX_LEN));
    new_len  = o_length + LW'(grow);
    psum     = PW'(pending) - PW'(grow) + (i_eat ? PW'(GROW_STEP) : PW'(0));
    nidx     = idx + LW'(1);
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = (nx == '0) || (nx == XW'(GRID_W + 1)) || (ny == '0) || (ny == YW'(GRID_H + 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT;
      o_head_x    <= XW'(START_X);
      o_head_y    <= YW'(START_Y);
      o_head_dir  <= 2'b11;
      o_pos_x     <= XW'(START_X);
      o_pos_y     <= YW'(START_Y);
      o_pos_dir   <= 2'b11;
      o_pos_first <= 1'b0;
      o_pos_last  <= 1'b0;
      o_pos_valid <= 1'b0;
      o_length    <= LW'(1);
      pending     <= '0;
      idx         <= '0;
      o_failure   <= 1'b0;
      o_success   <= 1'b0;
      o_tick_done <= 1'b0;
      for (int i = 0; i < HN; i++) hist[i] <= 2'b11;
    end else begin
      o_tick_done <= 1'b0;
      pending     <= (psum > PW'(MAX_LEN)) ? LW'(MAX_LEN) : psum[LW-1:0];
      case (state)
        WAIT: begin
          o_pos_valid <= 1'b0;
          o_pos_first <= 1'b0;
          o_pos_last  <= 1'b0;
          if (i_tick && !o_failure && !o_success) state <= MOVE;
        end
        MOVE: begin
          o_head_x    <= nx;
          o_head_y    <= ny;
          o_head_dir  <= eff_dir;
          hist[0]     <= eff_dir;
          for (int i = 1; i < HN; i++) hist[i] <= hist[i-1];
          o_length    <= new_len;
          if (new_len == LW'(MAX_LEN)) o_success <= 1'b1;
          if (wall_hit) o_failure <= 1'b1;
          o_tick_done <= 1'b1;
          o_pos_x     <= nx;
          o_pos_y     <= ny;
          o_pos_dir   <= eff_dir;
          idx         <= '0;
          o_pos_valid <= 1'b1;
          o_pos_first <= 1'b1;
          o_pos_last  <= (new_len == LW'(1));
          state       <= SCAN;
        end
        SCAN: begin
          if (!o_pos_first && o_pos_x == o_head_x && o_pos_y == o_head_y) o_failure <= 1'b1;
          if (o_pos_last) begin
            o_pos_valid <= 1'b0;
            o_pos_first <= 1'b0;
            o_pos_last  <= 1'b0;
            state       <= WAIT;
          end else begin
            o_pos_x     <= sx;
            o_pos_y     <= sy;
            o_pos_dir   <= hist[nidx];
            idx         <= nidx;
            o_pos_first <= 1'b0;
            o_pos_last  <= (nidx == o_length - LW'(1));
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snake_engine.sv
`default_nettype none
// ============================================================================
// tb_snake_engine: scoreboard bench for snake_engine against a trail-based model.
// Revision: 1.0
// ============================================================================
module tb_snake_engine;

  localparam int GW = 16, GH = 14, ML = 16, GS = 2, SX = 8, SY = 7;
  localparam int XW = $clog2(GW + 2);
  localparam int YW = $clog2(GH + 2);
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0, rst = 1'b1, tick = 1'b0, eat = 1'b0;
  logic [1:0]    dir = 2'b00;
  logic          tick_done, pos_first, pos_last, pos_valid, failure, success;
  logic [XW-1:0] head_x, pos_x;
  logic [YW-1:0] head_y, pos_y;
  logic [1:0]    head_dir, pos_dir;
  logic [LW-1:0] length;

  always #5 clk = ~clk;

  snake_engine #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .GROW_STEP(GS),
                 .START_X(SX), .START_Y(SY)) dut (
    .clk(clk), .rst(rst), .i_tick(tick), .i_dir(dir), .i_eat(eat),
    .o_tick_done(tick_done), .o_head_x(head_x), .o_head_y(head_y), .o_head_dir(head_dir),
    .o_pos_x(pos_x), .o_pos_y(pos_y), .o_pos_dir(pos_dir), .o_pos_first(pos_first),
    .o_pos_last(pos_last), .o_pos_valid(pos_valid), .o_length(length),
    .o_failure(failure), .o_success(success));

  typedef struct {int kind; int a; int b; int c; int d;} exp_t;
  exp_t sb[$];
  exp_t me;
  int tests = 0, fails = 0;

  // model: the body is the first m_len entries of the trail of past head cells
  int m_hx, m_hy, m_hd, m_len, m_pend;
  bit m_fail, m_succ;
  int tx[$], ty[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wx(input int x);
`ifdef SNAKE_WRAP_EN
    return ((x - 1) % GW + GW) % GW + 1;
`else
    return x & ((1 << XW) - 1);
`endif
  endfunction

  function automatic int wy(input int y);
`ifdef SNAKE_WRAP_EN
    return ((y - 1) % GH + GH) % GH + 1;
`else
    return y & ((1 << YW) - 1);
`endif
  endfunction

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic push_exp(input int k, input int a, input int b, input int c, input int d);
    exp_t t;
    t.kind = k; t.a = a; t.b = b; t.c = c; t.d = d;
    sb.push_back(t);
  endtask

  task automatic model_reset();
    m_hx = SX; m_hy = SY; m_hd = 3; m_len = 1; m_pend = 0; m_fail = 0; m_succ = 0;
    tx.delete(); ty.delete();
    for (int k = 0; k < ML; k++) begin
      tx.push_back(wx(SX - k));
      ty.push_back(wy(SY));
    end
  endtask

  task automatic model_move(input int d, input bit eat_mid);
    int e;
    e = (d == opposite(m_hd)) ? m_hd : d;
    case (e)
      0: m_hy = wy(m_hy - 1);
      1: m_hy = wy(m_hy + 1);
      2: m_hx = wx(m_hx - 1);
      default: m_hx = wx(m_hx + 1);
    endcase
    m_hd = e;
    tx.push_front(m_hx);
    ty.push_front(m_hy);
    if (tx.size() > ML) begin
      void'(tx.pop_back());
      void'(ty.pop_back());
    end
    if (m_pend > 0 && m_len < ML) begin
      m_len++;
      m_pend--;
    end
    if (eat_mid) m_pend = (m_pend + GS > ML) ? ML : m_pend + GS;
    push_exp(0, m_hx, m_hy, m_hd, m_len);
    for (int i = 0; i < m_len; i++) push_exp(1, tx[i], ty[i], (i == 0), (i == m_len - 1));
    for (int i = 1; i < m_len; i++)
      if (tx[i] == m_hx && ty[i] == m_hy) m_fail = 1;
`ifndef SNAKE_WRAP_EN
    if (m_hx == 0 || m_hx == GW + 1 || m_hy == 0 || m_hy == GH + 1) m_fail = 1;
`endif
    if (m_len == ML) m_succ = 1;
  endtask

  // monitor: pops expectations whenever the DUT presents a move or a segment
  always @(negedge clk) begin
    if (!rst) begin
      if (tick_done) begin
        if (sb.size() == 0 || sb[0].kind != 0) begin
          tests++; fails++;
          $display("FAIL tick_done: got unexpected pulse, expected none");
        end else begin
          me = sb.pop_front();
          check("head_x", head_x, me.a);
          check("head_y", head_y, me.b);
          check("head_dir", head_dir, me.c);
          check("length_at_move", length, me.d);
        end
      end
      if (pos_valid) begin
        if (sb.size() == 0 || sb[0].kind != 1) begin
          tests++; fails++;
          $display("FAIL pos_valid: got unexpected segment (%0d,%0d), expected none", pos_x, pos_y);
        end else begin
          me = sb.pop_front();
          check("pos_x", pos_x, me.a);
          check("pos_y", pos_y, me.b);
          check("pos_first", pos_first, me.c);
          check("pos_last", pos_last, me.d);
        end
      end
    end
  end

  task automatic check_reset_values();
    check("rst_head_x", head_x, SX);
    check("rst_head_y", head_y, SY);
    check("rst_head_dir", head_dir, 3);
    check("rst_length", length, 1);
    check("rst_failure", failure, 0);
    check("rst_success", success, 0);
    check("rst_tick_done", tick_done, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_pos_first", pos_first, 0);
    check("rst_pos_last", pos_last, 0);
  endtask

  task automatic apply_reset();
    #1;
    rst = 1'b1; tick = 1'b0; eat = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic eat_pulse();
    @(negedge clk);
    eat = 1'b1;
    m_pend = (m_pend + GS > ML) ? ML : m_pend + GS;
    @(negedge clk);
    eat = 1'b0;
  endtask

  task automatic wait_done(input bit eat_mid, output bit seen);
    seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      eat = (eat_mid && k == 1);
      if (tick_done) begin
        seen = 1;
        tick = 1'b0;
      end
    end
    eat = 1'b0;
    tick = 1'b0;
    if (!seen) begin
      check("tick_done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic do_tick(input int d, input bit eat_mid);
    bit seen;
    int k;
    @(negedge clk);
    dir = d[1:0];
    if (m_fail || m_succ) begin
      tick = 1'b1;
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (tick_done) seen = 1;
      end
      tick = 1'b0;
      check("ignored_tick_done", seen, 0);
      return;
    end
    model_move(d, eat_mid);
    tick = 1'b1;
    wait_done(eat_mid, seen);
    k = 0;
    while (pos_valid && k < ML + 4) begin
      @(negedge clk);
      k++;
    end
    check("scan_end", pos_valid, 0);
    check("sb_drained", sb.size(), 0);
    check("failure", failure, m_fail);
    check("success", success, m_succ);
    check("length", length, m_len);
  endtask

  task automatic tick_then_reset(input int d);
    bit seen;
    @(negedge clk);
    dir = d[1:0];
    model_move(d, 1'b0);
    tick = 1'b1;
    wait_done(1'b0, seen);
    @(negedge clk);
    check("midscan_valid", pos_valid, 1);
    apply_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();

    do_tick(3, 0);
    do_tick(2, 0);
    repeat (3) eat_pulse();
    do_tick(0, 0); do_tick(0, 0); do_tick(0, 0);
    do_tick(2, 0); do_tick(2, 0); do_tick(2, 0);
    do_tick(2, 1);
    do_tick(2, 0);
    tick_then_reset(0);

    repeat (2) eat_pulse();
    repeat (4) do_tick(3, 0);
    do_tick(0, 0); do_tick(2, 0); do_tick(1, 0); do_tick(3, 0);

    apply_reset();
    repeat (9) do_tick(3, 0);
    do_tick(3, 0);

    apply_reset();
    repeat (10) eat_pulse();
    repeat (8) do_tick(3, 0);
    repeat (6) do_tick(1, 0);
    do_tick(2, 0);
    do_tick(2, 0);

    for (int g = 0; g < 4; g++) begin
      apply_reset();
      for (int t = 0; t < 80 && !(m_fail || m_succ); t++) begin
        if ($urandom_range(0, 2) == 0) eat_pulse();
        do_tick(int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      end
      do_tick(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter GRID_W, default 16: playfield columns 1..GRID_W; columns 0 and GRID_W+1 are walls.
REQ-002 Parameter GRID_H, default 14: playfield rows 1..GRID_H; rows 0 and GRID_H+1 are walls.
REQ-003 Parameter MAX_LEN, default 64: maximum segment count, 2..256.
REQ-004 Parameter GROW_STEP, default 1: segments added per eat event, 1..15.
REQ-005 Parameters START_X default 8 and START_Y default 7: head position after reset.
REQ-006 Widths: XW=$clog2(GRID_W+2), YW=$clog2(GRID_H+2), LW=$clog2(MAX_LEN+1).
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 i_tick  in  1  move request; held until o_tick_done.
REQ-010 i_dir  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-011 i_eat  in  1  single-cycle eat pulse.
REQ-012 o_tick_done  out  1  one-cycle pulse when a move is applied.
REQ-013 o_head_x/o_head_y/o_head_dir  out  XW/YW/2  current head position and direction.
REQ-014 o_pos_x/o_pos_y/o_pos_dir  out  XW/YW/2  segment currently being scanned and its stored direction.
REQ-015 o_pos_first/o_pos_last/o_pos_valid  out  1 each  scanned segment is head / is tail / is valid.
REQ-016 o_length  out  LW  current segment count.
REQ-017 o_failure/o_success  out  1 each  sticky game-over flags.

Function
REQ-018 FSM states: WAIT, MOVE, SCAN; o_pos_valid SHALL be 1 only in SCAN.
REQ-019 WAIT: i_tick=1 with both flags clear SHALL go to MOVE next cycle; otherwise remain in WAIT.
REQ-020 MOVE (one cycle): update head one cell along the effective direction, push it into the direction history, pulse o_tick_done, go to SCAN.
REQ-021 Effective direction: i_dir, except the exact opposite of o_head_dir (codes differing only in bit 0), which SHALL be replaced by o_head_dir.
REQ-022 SCAN: one segment per cycle, index 0 (head, o_pos_first=1) to length-1 (o_pos_last=1), each next segment one cell opposite its predecessor's stored direction; then WAIT.
REQ-023 Growth: each i_eat pulse adds GROW_STEP to a pending counter saturating at MAX_LEN; in MOVE, pending>0 and length<MAX_LEN increments length and decrements pending.
REQ-024 i_eat coincident with MOVE SHALL be counted, taking effect at the next MOVE at the earliest.
REQ-025 o_failure SHALL set when a scanned segment with index>=1 equals the head position, or per REQ-034.
REQ-026 o_success SHALL set when length reaches MAX_LEN.
REQ-027 With either flag set, i_tick SHALL be ignored and o_tick_done SHALL stay 0; the in-progress SCAN still completes.
REQ-028 Length 1: SCAN lasts one cycle, o_pos_first and o_pos_last both 1.

Reset
REQ-029 rst=1 at a clock edge SHALL abort any state, including mid-SCAN, and enter WAIT.
REQ-030 Reset values: head=(START_X,START_Y), head_dir=11, length=1, pending=0, o_failure=0, o_success=0, o_tick_done=0, o_pos_valid=0, o_pos_first=0, o_pos_last=0.
REQ-031 Direction history SHALL reset to all 11.

Configuration
REQ-032 Macro SNAKE_WRAP_EN selects wrap-around walls.
REQ-033 Defined: a move off the playfield SHALL re-enter on the opposite edge (x 1->GRID_W, GRID_W->1; same for y); SCAN coordinates wrap identically; walls never cause failure.
REQ-034 Undefined: the head SHALL enter wall row/column 0 or GRID_W+1/GRID_H+1, and o_failure SHALL set in the cycle after MOVE.

Verification
REQ-035 Reset, tick with i_dir=11 -> o_tick_done pulse, head (9,7), one SCAN cycle with first=last=1.
REQ-036 Head_dir=11, tick with i_dir=10 -> direction rejected, head moves to (10,7), o_head_dir=11.
REQ-037 Three eat pulses, GROW_STEP=2, then 6 ticks -> o_length 1,2,...,7; SCAN lengths match.
REQ-038 Without SNAKE_WRAP_EN, 9 right ticks from (8,7) -> head (17,7), o_failure=1, further ticks give no o_tick_done.
REQ-039 With SNAKE_WRAP_EN, same stimulus -> head (1,7), o_failure=0.
REQ-040 Length 5, ticks up, left, down, right -> SCAN flags self-collision, o_failure=1; rst mid-SCAN -> all REQ-030 values next cycle.
